// File: rtl/uart_defs.sv
// Shared definitions for the UART transmitter: register offsets, FSM states,
// STATUS bit positions and the bit-time helper.
package uart_defs;

  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_STAT = 2'd1;
  localparam logic [1:0] UART_CTRL = 2'd2;
  localparam logic [1:0] UART_DIV  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // A divisor of zero still yields a one-cycle bit.
  function automatic logic [15:0] bit_len(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with async-reset pointers; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, baud counter,
// serialiser FSM and a registered "drained and idle" interrupt.
module uart_tx_dev
  import uart_defs::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        txd_q, txd_d;
  logic        irq_q, irq_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  logic        data_wr, fifo_pop, fifo_full, fifo_empty, busy, baud_last;
  logic [7:0]  fifo_dout;
  logic [1:0]  sel;
  logic [3:0]  stat;
  logic        unused_bits;

  assign sel         = Addr[3:2];
  assign data_wr     = WE && (sel == UART_DATA);
  assign busy        = (state_q != ST_IDLE);
  assign baud_last   = (baud_q <= 16'd1);
  assign unused_bits = ^{Addr[31:4], Din[31:16]};
  assign txd         = txd_q;
  assign IRQ         = irq_q;

  uart_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (data_wr),
    .pop  (fifo_pop),
    .din  (Din[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Serialiser: every bit boundary reloads the counter from the live divisor.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (ctrl_q[0] && !fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          state_d  = ST_START;
          txd_d    = 1'b0;
          baud_d   = bit_len(div_q);
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d  = ST_DATA;
          bitcnt_d = 3'd0;
          txd_d    = shreg_q[0];
          baud_d   = bit_len(div_q);
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = bit_len(div_q);
          if (bitcnt_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            shreg_d  = shreg_q >> 1;
            txd_d    = shreg_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          // Chain straight into the next START so frames are gapless.
          if (ctrl_q[0] && !fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            state_d  = ST_START;
            txd_d    = 1'b0;
            baud_d   = bit_len(div_q);
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    div_d  = div_q;
    ovf_d  = ovf_q;
    if (WE && (sel == UART_CTRL)) ctrl_d = Din[1:0];
    if (WE && (sel == UART_DIV))  div_d  = Din[15:0];
    if (WE && (sel == UART_STAT)) ovf_d = 1'b0;
    else if (data_wr && fifo_full && !fifo_pop) ovf_d = 1'b1;
    // A DATA write drops the interrupt on the very next edge.
    irq_d = ctrl_q[1] && fifo_empty && !busy && !data_wr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bitcnt_q <= '0;
      txd_q    <= 1'b1;
      irq_q    <= 1'b0;
      ctrl_q   <= '0;
      div_q    <= DEFAULT_DIV;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      txd_q    <= txd_d;
      irq_q    <= irq_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_comb begin
    stat             = '0;
    stat[STAT_FULL]  = fifo_full;
    stat[STAT_EMPTY] = fifo_empty;
    stat[STAT_BUSY]  = busy;
    stat[STAT_OVF]   = ovf_q;
    Dout = '0;
    case (sel)
      UART_DATA: Dout = '0;
      UART_STAT: Dout = {28'b0, stat};
      UART_CTRL: Dout = {30'b0, ctrl_q};
      UART_DIV:  Dout = {16'b0, div_q};
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register reset values, frame shape, FIFO
// overflow, back-to-back frames with IRQ, async reset and the zero divisor.
module tb_uart_tx_dev;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  int checks = 0;
  int errors = 0;

  uart_tx_dev #(
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ),
    .txd  (txd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    WE    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns on the falling edge after the rising edge that sampled WE.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = {28'd0, a};
    #1;
    v = Dout;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    do_reset();
    rd(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp %h", v, 32'h0); end
    rd(2'd1, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", v, 32'h2); end
    rd(2'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp %h", v, 32'h0); end
    rd(2'd3, v);
    checks++; if (v !== 32'd434) begin errors++; $display("FAIL reset_div got %h exp %h", v, 32'd434); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", IRQ); end
  endtask

  task automatic test_frame;
    logic [7:0] b;
    logic       exp;
    int         idx;
    b = 8'hA5;
    do_reset();
    wr(2'd3, 32'd4);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'hA5);
    Addr = 30'd1;
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      idx = (n - 1) / 4;
      if (idx == 0) exp = 1'b0;
      else if (idx <= 8) exp = b[idx-1];
      else exp = 1'b1;
      checks++; if (txd !== exp) begin errors++; $display("FAIL frame_txd n=%0d got %b exp %b", n, txd, exp); end
      if (n == 40) begin
        checks++; if (Dout[2] !== 1'b1) begin errors++; $display("FAIL frame_busy_end got %b exp 1", Dout[2]); end
      end
      if (n == 41) begin
        checks++; if (Dout !== 32'h2) begin errors++; $display("FAIL frame_status_idle got %h exp %h", Dout, 32'h2); end
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 8; i++) wr(2'd0, 32'h10 + i);
    rd(2'd1, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL ovf_full got %h exp %h", v, 32'h1); end
    wr(2'd0, 32'h99);
    rd(2'd1, v);
    checks++; if (v !== 32'h9) begin errors++; $display("FAIL ovf_set got %h exp %h", v, 32'h9); end
    wr(2'd1, 32'h0);
    rd(2'd1, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL ovf_clear got %h exp %h", v, 32'h1); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b0, b1;
    logic       exp;
    logic       exp_irq;
    int         idx;
    b0 = 8'h0F;
    b1 = 8'hF0;
    do_reset();
    wr(2'd3, 32'd2);
    wr(2'd0, 32'h0F);
    wr(2'd0, 32'hF0);
    wr(2'd2, 32'd3);
    Addr = 30'd1;
    for (int n = 1; n <= 43; n++) begin
      @(negedge clk);
      if (n <= 20) begin
        idx = (n - 1) / 2;
        exp = (idx == 0) ? 1'b0 : (idx <= 8) ? b0[idx-1] : 1'b1;
      end else if (n <= 40) begin
        idx = (n - 21) / 2;
        exp = (idx == 0) ? 1'b0 : (idx <= 8) ? b1[idx-1] : 1'b1;
      end else begin
        exp = 1'b1;
      end
      checks++; if (txd !== exp) begin errors++; $display("FAIL b2b_txd n=%0d got %b exp %b", n, txd, exp); end
      exp_irq = (n >= 42);
      checks++; if (IRQ !== exp_irq) begin errors++; $display("FAIL b2b_irq n=%0d got %b exp %b", n, IRQ, exp_irq); end
      if (n == 21) begin
        checks++; if (Dout[2] !== 1'b1) begin errors++; $display("FAIL b2b_gap_busy got %b exp 1", Dout[2]); end
      end
      if (n == 41) begin
        checks++; if (Dout[2] !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", Dout[2]); end
      end
    end
    wr(2'd0, 32'h11);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL b2b_irq_drop got %b exp 0", IRQ); end
  endtask

  task automatic test_async_reset;
    do_reset();
    wr(2'd3, 32'd4);
    wr(2'd0, 32'h00);
    wr(2'd0, 32'h00);
    wr(2'd2, 32'd3);
    Addr = 30'd1;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL arst_pre_txd got %b exp 0", txd); end
    checks++; if (Dout !== 32'h4) begin errors++; $display("FAIL arst_pre_status got %h exp %h", Dout, 32'h4); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL arst_txd got %b exp 1", txd); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL arst_irq got %b exp 0", IRQ); end
    checks++; if (Dout !== 32'h2) begin errors++; $display("FAIL arst_status got %h exp %h", Dout, 32'h2); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_div_zero;
    logic [31:0] v;
    logic [7:0]  b;
    logic        exp;
    int          idx;
    b = 8'h3C;
    do_reset();
    wr(2'd3, 32'd0);
    rd(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL div0_read got %h exp %h", v, 32'h0); end
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h3C);
    Addr = 30'd1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      idx = n - 1;
      exp = (idx == 0) ? 1'b0 : (idx <= 8) ? b[idx-1] : 1'b1;
      checks++; if (txd !== exp) begin errors++; $display("FAIL div0_txd n=%0d got %b exp %b", n, txd, exp); end
      if (n == 10) begin
        checks++; if (Dout[2] !== 1'b1) begin errors++; $display("FAIL div0_busy_stop got %b exp 1", Dout[2]); end
      end
      if (n == 11) begin
        checks++; if (Dout[2] !== 1'b0) begin errors++; $display("FAIL div0_busy_idle got %b exp 0", Dout[2]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    test_reset();
    test_frame();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_div_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
